// File: rtl/bus_rr_arbiter8.sv
// bus_rr_arbiter8: round-robin arbiter sharing one 32-bit datapath among
// 8 requesters. The winner keeps ownership until it signals done or
// drops its request. The select output keeps the last owner so the data
// mux stays stable.
//
// Optional feature: define ARB_TIMEOUT_EN to force a release after
// MAX_HOLD owned cycles, with a one-cycle timeout_flag pulse. Without it
// there is no hold counter and timeout_flag is constant 0.
module bus_rr_arbiter8 #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] sel,
  output logic       busy,
  output logic       timeout_flag
);

  // Elaboration-time guard on the hold configuration.
  if ((MAX_HOLD < 2) || (MAX_HOLD > 255) || ((MAX_HOLD >> CNT_W) != 0)) begin : g_bad_cfg
    $error("bus_rr_arbiter8: MAX_HOLD must be 2..255 and below 2**CNT_W");
  end

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] gnt_q, gnt_d;
  logic [2:0] sel_q, sel_d;
  logic [2:0] ptr_q, ptr_d;
  logic       busy_q, busy_d;
  logic       tflag_q, tflag_d;

  // Request vector rotated so that bit 0 is the requester at ptr.
  logic [7:0] req_rot;
  logic [2:0] win_off;
  logic [2:0] win_idx;
  logic       any_req;

  // Release qualifiers while owning.
  logic       owner_req;
  logic       timeout_hit;
  logic       rel_now;
  logic       forced_rel;

  genvar gi;
  for (gi = 0; gi < 8; gi++) begin : g_rot
    // 3-bit sum wraps naturally, giving (gi + ptr) mod 8.
    assign req_rot[gi] = req[3'(gi) + ptr_q];
  end

  assign any_req = |req;

  // Find the lowest set bit of the rotated vector (nearest to ptr).
  always_comb begin
    win_off = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (req_rot[i]) begin
        win_off = 3'(i);
      end
    end
  end

  // Convert the rotated offset back to an absolute requester index.
  assign win_idx = ptr_q + win_off;

  // sel_q always holds the owner index while in OWN.
  assign owner_req = req[sel_q];

`ifdef ARB_TIMEOUT_EN
  // Counter value seen on the edge that completes the MAX_HOLD-th owned cycle.
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

  // Hold counter: zero outside OWN, so it starts at 0 on entry, then +1 per owned cycle.
  always_comb begin
    hold_cnt_d = '0;
    if ((state_q == ST_OWN) && !rel_now) begin
      hold_cnt_d = hold_cnt_q + CNT_W'(1);
    end
  end

  // Hold counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_q <= '0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign timeout_hit = (state_q == ST_OWN) && (hold_cnt_q == HOLD_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  // A normal release (done or abandon) takes precedence over a timeout,
  // so the flag only marks releases caused purely by the hold limit.
  assign rel_now    = done || !owner_req || timeout_hit;
  assign forced_rel = timeout_hit && !done && owner_req;

  // Next-state and next-output computation for the two-state arbiter.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    busy_d  = busy_q;
    tflag_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // No grant while idle; sel keeps the last owner for mux stability.
        gnt_d  = 8'h00;
        busy_d = 1'b0;
        if (any_req) begin
          state_d = ST_OWN;
          gnt_d   = 8'h01 << win_idx;
          sel_d   = win_idx;
          busy_d  = 1'b1;
        end
      end
      ST_OWN: begin
        // Other requesters are ignored until the owner lets go.
        if (rel_now) begin
          state_d = ST_IDLE;
          gnt_d   = 8'h00;
          busy_d  = 1'b0;
          ptr_d   = sel_q + 3'd1;
          tflag_d = forced_rel;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = 8'h00;
        busy_d  = 1'b0;
      end
    endcase
  end

  // FSM state and all registered outputs; reset drops any grant at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= 8'h00;
      sel_q   <= 3'd0;
      ptr_q   <= 3'd0;
      busy_q  <= 1'b0;
      tflag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
      tflag_q <= tflag_d;
    end
  end

  assign gnt          = gnt_q;
  assign sel          = sel_q;
  assign busy         = busy_q;
  assign timeout_flag = tflag_q;

endmodule

// File: doc/bus_rr_arbiter8.md
Name: bus_rr_arbiter8

Overview:
- Round-robin arbiter that shares one 32-bit datapath resource among 8 requesters, such as a shared memory/bus port.
- Its outputs are a one-hot grant vector and a 3-bit select that drives the 8:1 32-bit data mux (mux_len32_sel8 `choose` input).
- Ownership is held until the owner signals completion, so the mux select stays stable for the whole transfer.

Parameters:
- MAX_HOLD, 16: maximum number of cycles one owner may hold the resource. Used only when ARB_TIMEOUT_EN is defined. Legal range 2..255.
- CNT_W, 8: width of the hold counter. Must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  single system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  8  request vector; bit i = requester i wants the resource.
- done  input  1  the current owner has finished; sampled only in OWN.
- gnt  output  8  one-hot grant, registered; all-zero when no owner.
- sel  output  3  binary index of the current or last owner; drives the mux `choose`.
- busy  output  1  high while in OWN.
- timeout_flag  output  1  one-cycle pulse on a forced release.

Behaviour:
- Reset (rst_n low, asynchronous, no clock needed):
  - Outputs: gnt=0, sel=0, busy=0, timeout_flag=0.
  - Internal: state=IDLE, ptr=0, hold counter=0.
  - Reset mid-OWN drops the grant immediately; the interrupted transfer is not resumed.
- State machine: two states, IDLE and OWN.
- IDLE:
  - If req != 0, pick the first set bit scanning ptr, ptr+1, … ptr+7, all indices mod 8 (wrap 7→0).
  - On the next edge: gnt = onehot(winner), sel = winner, busy=1, state=OWN.
  - Latency from req sampled high to gnt high: 1 cycle.
  - If req == 0: remain in IDLE; gnt=0; sel holds its last value (keeps the mux output stable).
  - done is ignored in IDLE.
- OWN:
  - gnt, sel and busy hold steady.
  - Requests from non-owners are ignored until release.
- Release conditions, checked on each OWN edge:
  - (a) done=1.
  - (b) req[owner]=0, i.e. the owner abandons.
  - (c) timeout, only with ARB_TIMEOUT_EN.
- On release, at the next edge:
  - gnt=0, busy=0, ptr = (owner+1) mod 8, state=IDLE.
  - sel keeps the owner index.
- Turnaround: exactly one IDLE cycle with gnt=0 always separates two grants. There are no back-to-back grants.
- Fairness: the most recent winner becomes lowest priority. With all 8 requesting continuously, grant order is 0,1,…,7,0.
- Simultaneous events: done and owner req drop in the same cycle form a single release. Timeout and done in the same cycle count as a normal release with timeout_flag=0.
- gnt is always one-hot or zero. sel always equals the index of the set gnt bit whenever gnt != 0.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - Hold counter clears on entry to OWN and increments on each OWN cycle.
  - When it reaches MAX_HOLD with no done, the arbiter releases as in (c) on that edge.
  - timeout_flag=1 for exactly the one cycle in which gnt goes to 0; ptr advances normally.
- Undefined:
  - No counter logic is present; timeout_flag is tied to 0.
  - An owner may hold the resource indefinitely.

Test Plan:
- Reset: assert rst_n=0 asynchronously mid-OWN with gnt=0x04 → gnt=0, sel=0, busy=0 before the next clock edge. After release, req=0x04 → gnt=0x04 one cycle later (ptr was reset to 0).
- Basic grant: after reset, req=0x81 → next cycle gnt=0x01, sel=0, busy=1. Pulse done → next cycle gnt=0, busy=0, sel=0 still. Following cycle gnt=0x80, sel=7.
- Full rotation: req=0xFF held, done pulsed one cycle after each grant → gnt sequence 0x01,0x02,…,0x80,0x01, each separated by one gnt=0 cycle.
- Wrap and priority: owner 6 releases (ptr=7), then req=0x41 → gnt=0x01, sel=0 (scan 7→0 wraps before reaching 6).
- Abandon: owner 3 holding (gnt=0x08) drops req[3] with done=0 → next cycle gnt=0, ptr=4. With req=0x18 the next grant is 0x10.
- Timeout (ARB_TIMEOUT_EN, MAX_HOLD=16): owner 2 holds with done=0 → on the 16th OWN cycle edge gnt=0 and timeout_flag=1 for one cycle. Without the macro: gnt=0x04 still set after 100 cycles; timeout_flag stays 0.
